// File: rtl/shift_rows_pipe.sv
// Registered AES/Rijndael ShiftRows stage for NB = 4, 6 or 8 state columns.
// The row rotation is applied combinationally to the incoming state, so only
// permuted data and its mode bit are stored. A main output register plus one
// skid register keep s_ready registered, with no combinational path from
// m_ready back to s_ready.
//
// Handshake: a beat moves on a rising edge where valid and ready are both 1.
// While m_valid = 1 and m_ready = 0, m_data/m_inv hold stable. s_ready only
// depends on occupancy, never on s_valid or m_ready in the same cycle.
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int W     = 32 * NB,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    input  logic             s_inv,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data,
    output logic             m_inv,
    output logic [CNT_W-1:0] xfer_count,
    output logic             busy
);

    // Only the three Rijndael block sizes have defined row offsets.
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    // W is derived from NB and exists only for port sizing.
    if (W != 32 * NB) begin : g_bad_w
        $error("shift_rows_pipe: W must equal 32*NB");
    end

    // Row rotation amount; the 256-bit block uses 0,1,3,4.
    function automatic int row_off(input int r);
        return (NB == 8 && r >= 2) ? r + 1 : r;
    endfunction

    // Occupancy of the main + skid registers, exposed for checkers.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           s_ready_q;
    logic [W-1:0]   perm_data;
    logic [W-1:0]   main_data_q;
    logic           main_inv_q;
    logic [W-1:0]   skid_data_q;
    logic           skid_inv_q;
    logic [CNT_W-1:0] count_q;
    logic           push;
    logic           pop;
    logic           load_main_in;
    logic           load_main_skid;
    logic           load_skid;

    assign push = s_valid & s_ready_q;
    assign pop  = m_valid & m_ready;

    // Byte-level row rotation of the incoming state (column-major byte map).
    always_comb begin
        perm_data = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                perm_data[W-1-8*(4*c+r) -: 8] = s_inv
                    ? s_data[W-1-8*(4*((c - row_off(r) + NB) % NB) + r) -: 8]
                    : s_data[W-1-8*(4*((c + row_off(r)) % NB) + r) -: 8];
            end
        end
    end

    // Occupancy next-state and register load selects.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    load_main_in = 1'b1;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_main_in = 1'b1;
                end else if (push) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    load_main_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Occupancy, registered ready and output handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            s_ready_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d != FULL);
            if (pop) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Main output register and skid register datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q <= '0;
            main_inv_q  <= 1'b0;
            skid_data_q <= '0;
            skid_inv_q  <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_data_q <= perm_data;
                main_inv_q  <= s_inv;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_inv_q  <= skid_inv_q;
            end
            if (load_skid) begin
                skid_data_q <= perm_data;
                skid_inv_q  <= s_inv;
            end
        end
    end

    assign s_ready    = s_ready_q;
    assign m_valid    = (state_q != EMPTY);
    assign m_data     = main_data_q;
    assign m_inv      = main_inv_q;
    assign xfer_count = count_q;
    assign busy       = (state_q != EMPTY);

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: NB=4 main instance, NB=8 and NB=6
// instances for the other block sizes, and an NB=4 instance with a 2-bit
// counter for wrap-around.
module tb_shift_rows_pipe;

    localparam logic [127:0] SEQ4 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FWD4 = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] INV4 = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [127:0] FWD4X2 = 128'h0009020b040d060f08010a030c050e07;
    localparam logic [255:0] SEQ8 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] FWD8 =
        256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;
    localparam logic [191:0] SEQ6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [191:0] FWD6 = 192'h00050a0f_04090e13_080d1217_0c111603_10150207_1401060b;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // NB=4 main instance
    logic         s_valid, s_ready, s_inv, m_valid, m_ready, m_inv, busy;
    logic [127:0] s_data, m_data;
    logic [15:0]  xfer_count;
    // NB=8 instance
    logic         d8_s_valid, d8_s_ready, d8_s_inv, d8_m_valid, d8_m_ready, d8_m_inv, d8_busy;
    logic [255:0] d8_s_data, d8_m_data;
    logic [15:0]  d8_xfer_count;
    // NB=6 instance
    logic         d6_s_valid, d6_s_ready, d6_s_inv, d6_m_valid, d6_m_ready, d6_m_inv, d6_busy;
    logic [191:0] d6_s_data, d6_m_data;
    logic [15:0]  d6_xfer_count;
    // NB=4, 2-bit counter instance
    logic         dw_s_valid, dw_s_ready, dw_s_inv, dw_m_valid, dw_m_ready, dw_m_inv, dw_busy;
    logic [127:0] dw_s_data, dw_m_data;
    logic [1:0]   dw_xfer_count;

    shift_rows_pipe #(.NB(4)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_inv(s_inv), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_inv(m_inv), .xfer_count(xfer_count), .busy(busy));

    shift_rows_pipe #(.NB(8)) dut8 (
        .clk(clk), .rst(rst), .s_valid(d8_s_valid), .s_ready(d8_s_ready), .s_data(d8_s_data),
        .s_inv(d8_s_inv), .m_valid(d8_m_valid), .m_ready(d8_m_ready), .m_data(d8_m_data),
        .m_inv(d8_m_inv), .xfer_count(d8_xfer_count), .busy(d8_busy));

    shift_rows_pipe #(.NB(6)) dut6 (
        .clk(clk), .rst(rst), .s_valid(d6_s_valid), .s_ready(d6_s_ready), .s_data(d6_s_data),
        .s_inv(d6_s_inv), .m_valid(d6_m_valid), .m_ready(d6_m_ready), .m_data(d6_m_data),
        .m_inv(d6_m_inv), .xfer_count(d6_xfer_count), .busy(d6_busy));

    shift_rows_pipe #(.NB(4), .CNT_W(2)) dutw (
        .clk(clk), .rst(rst), .s_valid(dw_s_valid), .s_ready(dw_s_ready), .s_data(dw_s_data),
        .s_inv(dw_s_inv), .m_valid(dw_m_valid), .m_ready(dw_m_ready), .m_data(dw_m_data),
        .m_inv(dw_m_inv), .xfer_count(dw_xfer_count), .busy(dw_busy));

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_xfer = '0;
    logic [128:0] exp_q[$];

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: NB=4 ShiftRows over a byte array.
    function automatic logic [127:0] ref4(input logic [127:0] d, input logic inv);
        logic [7:0] b [16];
        logic [127:0] o;
        int src;
        for (int k = 0; k < 16; k++) b[k] = d[127-8*k -: 8];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = b[4*src+r];
            end
        end
        return o;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b1; s_data = SEQ4; s_inv = 1'b1; m_ready = 1'b0;
        repeat (2) tick();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b expected 0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (m_data !== 128'h0) begin errors++; $display("FAIL rst_m_data: got %h expected 0", m_data); end
        checks++; if (m_inv !== 1'b0) begin errors++; $display("FAIL rst_m_inv: got %b expected 0", m_inv); end
        checks++; if (xfer_count !== 16'h0) begin errors++; $display("FAIL rst_xfer: got %0d expected 0", xfer_count); end
        rst = 1'b0;
        tick();
        // s_valid was high, but s_ready was still 0 at this edge
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_ignore_in: m_valid got %b expected 0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", s_ready); end
        s_valid = 1'b0;
        exp_xfer = '0;
    endtask

    task automatic test_forward();
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = SEQ4; s_inv = 1'b0;
        tick();
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid: got %b expected 1", m_valid); end
        checks++; if (m_data !== FWD4) begin errors++; $display("FAIL fwd_data: got %h expected %h", m_data, FWD4); end
        checks++; if (m_inv !== 1'b0) begin errors++; $display("FAIL fwd_inv: got %b expected 0", m_inv); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fwd_busy: got %b expected 1", busy); end
        tick();
        exp_xfer++;
        checks++; if (xfer_count !== exp_xfer) begin errors++; $display("FAIL fwd_xfer: got %0d expected %0d", xfer_count, exp_xfer); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fwd_drain: m_valid got %b expected 0", m_valid); end
    endtask

    task automatic test_inverse();
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = SEQ4; s_inv = 1'b1;
        tick();
        checks++; if (m_data !== INV4) begin errors++; $display("FAIL inv_data: got %h expected %h", m_data, INV4); end
        checks++; if (m_inv !== 1'b1) begin errors++; $display("FAIL inv_mode: got %b expected 1", m_inv); end
        s_data = INV4; s_inv = 1'b0;
        tick();
        exp_xfer++;
        s_valid = 1'b0;
        checks++; if (m_data !== SEQ4) begin errors++; $display("FAIL inv_roundtrip: got %h expected %h", m_data, SEQ4); end
        tick();
        exp_xfer++;
        checks++; if (xfer_count !== exp_xfer) begin errors++; $display("FAIL inv_xfer: got %0d expected %0d", xfer_count, exp_xfer); end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = SEQ4; s_inv = 1'b0;          // A
        tick();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a: got %b expected 1", s_ready); end
        s_data = SEQ4; s_inv = 1'b1;                          // B
        tick();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", s_ready); end
        checks++; if (m_data !== FWD4) begin errors++; $display("FAIL bp_head_a: got %h expected %h", m_data, FWD4); end
        s_data = FWD4; s_inv = 1'b0;                          // C, must be held off
        tick();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold: got %b expected 0", s_ready); end
        checks++; if (m_data !== FWD4 || m_inv !== 1'b0) begin errors++; $display("FAIL bp_stable: got %h/%b expected %h/0", m_data, m_inv, FWD4); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b expected 1", busy); end
        m_ready = 1'b1;
        tick();
        exp_xfer++;
        checks++; if (m_data !== INV4 || m_inv !== 1'b1) begin errors++; $display("FAIL bp_b: got %h/%b expected %h/1", m_data, m_inv, INV4); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", s_ready); end
        tick();
        exp_xfer++;
        s_valid = 1'b0;
        checks++; if (m_data !== FWD4X2 || m_inv !== 1'b0) begin errors++; $display("FAIL bp_c: got %h/%b expected %h/0", m_data, m_inv, FWD4X2); end
        tick();
        exp_xfer++;
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain: valid/busy got %b/%b expected 0/0", m_valid, busy); end
        checks++; if (xfer_count !== exp_xfer) begin errors++; $display("FAIL bp_xfer: got %0d expected %0d", xfer_count, exp_xfer); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] d;
        logic [128:0] exp;
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            s_valid = 1'b1; s_data = d; s_inv = i[0];
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, s_ready); end
            exp_q.push_back({i[0], ref4(d, i[0])});
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (m_valid !== 1'b1 || {m_inv, m_data} !== exp) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %b/%h expected 1/%h", i, m_valid, {m_inv, m_data}, exp);
            end
        end
        s_valid = 1'b0;
        tick();
        exp_xfer = exp_xfer + 16'd100;
        checks++; if (xfer_count !== exp_xfer) begin errors++; $display("FAIL b2b_xfer: got %0d expected %0d", xfer_count, exp_xfer); end
    endtask

    task automatic test_nb8();
        d8_m_ready = 1'b1;
        d8_s_valid = 1'b1; d8_s_data = SEQ8; d8_s_inv = 1'b0;
        tick();
        checks++; if (d8_m_data[255:224] !== 32'h00050e13) begin errors++; $display("FAIL nb8_col0: got %h expected 00050e13", d8_m_data[255:224]); end
        checks++; if (d8_m_data !== FWD8) begin errors++; $display("FAIL nb8_fwd: got %h expected %h", d8_m_data, FWD8); end
        d8_s_data = FWD8; d8_s_inv = 1'b1;
        tick();
        d8_s_valid = 1'b0;
        checks++; if (d8_m_data !== SEQ8 || d8_m_inv !== 1'b1) begin errors++; $display("FAIL nb8_inv: got %h/%b expected %h/1", d8_m_data, d8_m_inv, SEQ8); end
        tick();
        checks++; if (d8_xfer_count !== 16'd2 || d8_busy !== 1'b0) begin errors++; $display("FAIL nb8_xfer: got %0d/%b expected 2/0", d8_xfer_count, d8_busy); end
    endtask

    task automatic test_nb6();
        d6_m_ready = 1'b1;
        d6_s_valid = 1'b1; d6_s_data = SEQ6; d6_s_inv = 1'b0;
        tick();
        checks++; if (d6_m_data !== FWD6) begin errors++; $display("FAIL nb6_fwd: got %h expected %h", d6_m_data, FWD6); end
        d6_s_data = d6_m_data; d6_s_inv = 1'b1;
        tick();
        d6_s_valid = 1'b0;
        checks++; if (d6_m_data !== SEQ6) begin errors++; $display("FAIL nb6_roundtrip: got %h expected %h", d6_m_data, SEQ6); end
        tick();
        checks++; if (d6_m_valid !== 1'b0 || d6_s_ready !== 1'b1) begin errors++; $display("FAIL nb6_idle: valid/ready got %b/%b expected 0/1", d6_m_valid, d6_s_ready); end
    endtask

    task automatic test_reset_full();
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = SEQ4; s_inv = 1'b0;
        repeat (2) tick();
        checks++; if (s_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rf_full: ready/busy got %b/%b expected 0/1", s_ready, busy); end
        s_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rf_cleared: valid/busy got %b/%b expected 0/0", m_valid, busy); end
        checks++; if (xfer_count !== 16'h0 || m_data !== 128'h0) begin errors++; $display("FAIL rf_regs: xfer/data got %0d/%h expected 0/0", xfer_count, m_data); end
        rst = 1'b0;
        exp_xfer = '0;
        tick();
        checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL rf_release: ready/valid got %b/%b expected 1/0", s_ready, m_valid); end
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = SEQ4; s_inv = 1'b1;
        tick();
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b1 || m_data !== INV4) begin errors++; $display("FAIL rf_fresh: got %b/%h expected 1/%h", m_valid, m_data, INV4); end
        tick();
        exp_xfer++;
        checks++; if (xfer_count !== exp_xfer) begin errors++; $display("FAIL rf_xfer: got %0d expected %0d", xfer_count, exp_xfer); end
    endtask

    task automatic test_wrap();
        logic [1:0]   exp_cnt;
        logic [127:0] exp_d;
        exp_cnt = 2'd0;
        dw_m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            dw_s_valid = 1'b1; dw_s_data = SEQ4; dw_s_inv = i[0];
            exp_d = i[0] ? INV4 : FWD4;
            tick();
            dw_s_valid = 1'b0;
            checks++; if (dw_m_valid !== 1'b1 || dw_m_data !== exp_d) begin errors++; $display("FAIL wrap_data[%0d]: got %b/%h expected 1/%h", i, dw_m_valid, dw_m_data, exp_d); end
            tick();
            exp_cnt = exp_cnt + 2'd1;
            checks++; if (dw_xfer_count !== exp_cnt) begin errors++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", i, dw_xfer_count, exp_cnt); end
        end
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0; s_inv = 1'b0; m_ready = 1'b0;
        d8_s_valid = 1'b0; d8_s_data = '0; d8_s_inv = 1'b0; d8_m_ready = 1'b0;
        d6_s_valid = 1'b0; d6_s_data = '0; d6_s_inv = 1'b0; d6_m_ready = 1'b0;
        dw_s_valid = 1'b0; dw_s_data = '0; dw_s_inv = 1'b0; dw_m_ready = 1'b0;
        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_back_to_back();
        test_nb8();
        test_nb6();
        test_reset_full();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Registered, parametrised AES/Rijndael ShiftRows engine. Applies forward or inverse ShiftRows per transaction (mode travels with the data) on Rijndael states of NB columns (128/192/256-bit blocks). Sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey in the iterative round datapath. Uses valid/ready handshakes on both sides with a 2-entry skid buffer, so s_ready is a registered signal.

Parameters:
NB, 4, state columns; legal values 4, 6, 8; any other value is an elaboration error
W, 32*NB, state width in bits; derived, must not be overridden
CNT_W, 16, width of the completed-transfer counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
s_valid  input  1  input state valid
s_ready  output  1  block can accept a state; registered
s_data  input  W  input state
s_inv  input  1  0 = forward ShiftRows, 1 = InvShiftRows; sampled with s_data
m_valid  output  1  output state valid
m_ready  input  1  downstream accepts
m_data  output  W  shifted state; registered
m_inv  output  1  mode used for m_data
xfer_count  output  CNT_W  number of output handshakes since reset
busy  output  1  high when any skid entry is occupied

Behaviour:
- Byte map: byte k = 4*c + r (column-major) occupies s_data[W-1-8k -: 8]. Row r = 0..3, column c = 0..NB-1.
- Row offsets off[r]: NB=4 or 6 gives 0,1,2,3. NB=8 gives 0,1,3,4.
- Forward: out(r,c) = in(r, (c + off[r]) mod NB). Inverse: out(r,c) = in(r, (c - off[r] + NB) mod NB). Row 0 is never moved.
- Permutation is combinational on the input side. Only permuted data plus inv are stored.
- Storage: main output register and one skid register. Occupancy is 0, 1 or 2, giving states EMPTY, ONE, FULL.
- s_ready = 1 when occupancy < 2, registered. It drops the cycle after occupancy reaches 2.
- Input handshake: s_valid & s_ready at an edge. Output handshake: m_valid & m_ready at an edge.
- Latency: an accepted state appears on m_data/m_valid the next cycle when the main register is empty, or is empty-after-pop.
- EMPTY: on accept, load main; go to ONE.
- ONE, accept without pop: load skid; go to FULL. Pop without accept: go to EMPTY.
- ONE, accept and pop together: load main with the new state; stay ONE.
- FULL: s_ready = 0, so no accept. On pop: main <= skid; go to ONE.
- Ordering is strict FIFO. No state is dropped or duplicated.
- While m_valid = 1 and m_ready = 0, m_data and m_inv hold stable.
- xfer_count increments on every output handshake. It wraps from 2^CNT_W - 1 to 0.
- busy = (occupancy != 0).
- Reset, including mid-transfer: m_valid = 0, s_ready = 1 (taken the cycle after rst deasserts; during rst it is 0), m_data = 0, m_inv = 0, xfer_count = 0, busy = 0, occupancy = 0. All held entries are discarded. Inputs are ignored while rst = 1.
- No combinational path from m_ready to s_ready, or from s_* to m_*.

Test Plan:
- NB=4, forward: s_data = 0x000102030405060708090a0b0c0d0e0f, s_inv = 0, m_ready = 1 -> one cycle later m_data = 0x00050a0f04090e03080d02070c01060b, m_inv = 0, xfer_count = 1.
- NB=4, inverse: same s_data, s_inv = 1 -> m_data = 0x000d0a0704010e0b0805020f0c090603. Feed that result back with s_inv = 0 -> original 0x000102...0f returned.
- Backpressure: m_ready = 0, three back-to-back states A, B, C offered -> A and B accepted. s_ready = 0 from the cycle after B; C is held. Raise m_ready -> A, B, C emerge in order. m_data is stable while stalled.
- Simultaneous push/pop in ONE, streaming 100 random states with m_ready = 1 -> one result per cycle, s_ready never drops. Results match a reference model; mode toggles per beat.
- NB=8, forward: s_data bytes = 0x00..0x1f -> m_data column 0 = 00 05 0e 13 (offsets 0,1,3,4). NB=6 round trip restores the input.
- Reset while FULL -> next cycle m_valid = 0, busy = 0, xfer_count = 0. A fresh input then passes with 1-cycle latency. xfer_count wraps when CNT_W = 2 after 4 handshakes.
